// File: rtl/rail_pkg.sv
// rail_pkg: shared types and default constants for the level-crossing
// controller.
//   gate_state_e     : gate FSM state encoding (also driven on the state port)
//   CLK_HZ           : board clock frequency
//   DEF_TICK_DIV     : clocks per one-second tick at CLK_HZ
//   DEF_DEBOUNCE_CYC : stable clocks (10 ms) before a sensor is believed
package rail_pkg;

   typedef enum logic [1:0] {
      ST_OPEN   = 2'd0,
      ST_WARN   = 2'd1,
      ST_CLOSED = 2'd2,
      ST_CLEAR  = 2'd3
   } gate_state_e;

   localparam int CLK_HZ           = 100_000_000;
   localparam int DEF_TICK_DIV     = CLK_HZ;
   localparam int DEF_DEBOUNCE_CYC = 1_000_000;

endpackage

// File: rtl/rail_debounce.sv
// rail_debounce: one train-sensor channel.
//   The raw asynchronous switch passes through a 2-flop synchroniser. A
//   counter then measures how long the synchronised level has disagreed
//   with the debounced output. The output adopts the new level only after
//   DEBOUNCE_CYC consecutive disagreeing cycles.
// Ports:
//   clk_100MHz in  board clock
//   reset      in  synchronous, active-high
//   din        in  raw sensor level (asynchronous)
//   dout       out debounced sensor level
module rail_debounce
   import rail_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int CW = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          dout_q;
   logic          dout_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The counter only runs while the synchronised and debounced levels
   // disagree. Any agreement restarts the measurement.
   always_comb begin
      dout_d = dout_q;
      cnt_d  = '0;
      if (sync2_q != dout_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            dout_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/rail_gate_ctrl.sv
// rail_gate_ctrl: multi-track level-crossing gate controller.
//   Debounces one sensor per track and synchronises a maintenance
//   force_close input. Derives a one-cycle tick every TICK_DIV clocks and
//   sequences the gate OPEN -> WARN -> CLOSED -> CLEAR -> OPEN.
// Ports:
//   clk_100MHz    in  board clock
//   reset         in  synchronous, active-high
//   sensor        in  [N_TRACKS] raw train sensors, 1 = train present
//   force_close   in  maintenance override, acts as an extra occupancy source
//   led_gate_down out gate lowered (CLOSED or CLEAR)
//   led_gate_up   out gate raised (OPEN)
//   led_warn      out warning lamp, toggles on each tick in WARN/CLEAR
//   state         out current FSM state (gate_state_e encoding)
//   occ_cnt       out number of debounced-occupied tracks (registered)
//   pass_cnt      out completed close/reopen cycles, wraps at 16 bits
module rail_gate_ctrl
   import rail_pkg::*;
#(
   parameter int N_TRACKS     = 2,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int WARN_TICKS   = 3,
   parameter int CLEAR_TICKS  = 2
) (
   input  logic                              clk_100MHz,
   input  logic                              reset,
   input  logic [N_TRACKS-1:0]               sensor,
   input  logic                              force_close,
   output logic                              led_gate_down,
   output logic                              led_gate_up,
   output logic                              led_warn,
   output logic [1:0]                        state,
   output logic [$clog2(N_TRACKS+1)-1:0]     occ_cnt,
   output logic [15:0]                       pass_cnt
);

   localparam int OW    = $clog2(N_TRACKS + 1);
   localparam int PW    = $clog2(TICK_DIV);
   localparam int MAX_T = (WARN_TICKS > CLEAR_TICKS) ? WARN_TICKS : CLEAR_TICKS;
   localparam int TW    = $clog2(MAX_T + 1);

   // ---------------- input conditioning ----------------
   logic [N_TRACKS-1:0] deb;
   logic                fc_sync1_q;
   logic                fc_sync2_q;
   logic                occupied;

   for (genvar g = 0; g < N_TRACKS; g++) begin : g_track
      rail_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_deb (
         .clk_100MHz (clk_100MHz),
         .reset      (reset),
         .din        (sensor[g]),
         .dout       (deb[g])
      );
   end

   // force_close is a deliberate operator action, so it is synchronised
   // but deliberately not debounced.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         fc_sync1_q <= 1'b0;
         fc_sync2_q <= 1'b0;
      end else begin
         fc_sync1_q <= force_close;
         fc_sync2_q <= fc_sync1_q;
      end
   end

   assign occupied = (|deb) | fc_sync2_q;

   // occ_cnt counts real tracks only; the override is not a track.
   logic [OW-1:0] occ_sum;
   logic [OW-1:0] occ_cnt_q;

   always_comb begin
      occ_sum = '0;
      for (int i = 0; i < N_TRACKS; i++) begin
         occ_sum = occ_sum + OW'(deb[i]);
      end
   end

   // ---------------- prescaler ----------------
   logic [PW-1:0] pre_q;
   logic          tick;

   assign tick = (pre_q == PW'(TICK_DIV - 1));

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         pre_q     <= '0;
         occ_cnt_q <= '0;
      end else begin
         pre_q     <= tick ? '0 : pre_q + PW'(1);
         occ_cnt_q <= occ_sum;
      end
   end

   // ---------------- FSM ----------------
   gate_state_e   state_q;
   gate_state_e   state_d;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   logic [15:0]   pass_cnt_q;
   logic [15:0]   pass_cnt_d;
   logic          led_warn_q;
   logic          led_warn_d;
   logic          timed_exit;

   // The timer holds the number of ticks still to elapse in the phase;
   // the tick that takes it from 1 to 0 is the one that ends the phase.
   assign timed_exit = tick && (timer_q == TW'(1));

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q    <= ST_OPEN;
         timer_q    <= '0;
         pass_cnt_q <= '0;
         led_warn_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pass_cnt_q <= pass_cnt_d;
         led_warn_q <= led_warn_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      pass_cnt_d = pass_cnt_q;
      if (tick && (timer_q != '0)) begin
         timer_d = timer_q - TW'(1);
      end
      unique case (state_q)
         ST_OPEN: begin
            if (occupied) begin
               state_d = ST_WARN;
               timer_d = TW'(WARN_TICKS);
            end
         end
         ST_WARN: begin
            // Once warning has started the gate always closes, even if
            // the train sensor drops out meanwhile.
            if (timed_exit) begin
               state_d = ST_CLOSED;
               timer_d = '0;
            end
         end
         ST_CLOSED: begin
            if (!occupied) begin
               state_d = ST_CLEAR;
               timer_d = TW'(CLEAR_TICKS);
            end
         end
         ST_CLEAR: begin
            // A new arrival outranks an expiring clearance timer.
            if (occupied) begin
               state_d = ST_CLOSED;
               timer_d = '0;
            end else if (timed_exit) begin
               state_d    = ST_OPEN;
               timer_d    = '0;
               pass_cnt_d = pass_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_OPEN;
            timer_d = '0;
         end
      endcase
   end

   // Warning lamp restarts dark on every state entry, so in OPEN/CLOSED it
   // stays 0 and in WARN/CLEAR it blinks from a known phase.
   always_comb begin
      led_warn_d = led_warn_q;
      if (state_d != state_q) begin
         led_warn_d = 1'b0;
      end else if (tick && ((state_q == ST_WARN) || (state_q == ST_CLEAR))) begin
         led_warn_d = ~led_warn_q;
      end
   end

   // Output decode straight from the state register.
   always_comb begin
      led_gate_up   = (state_q == ST_OPEN);
      led_gate_down = (state_q == ST_CLOSED) || (state_q == ST_CLEAR);
   end

   assign led_warn = led_warn_q;
   assign state    = state_q;
   assign occ_cnt  = occ_cnt_q;
   assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_rail_gate_ctrl.sv
// Testbench for rail_gate_ctrl with a short tick and debounce window.
// A reference model, written directly from the behavioural rules, advances
// once per rising edge and every output is compared with it each cycle.
// Directed latency and duration checks are layered on top.
module tb_rail_gate_ctrl;

   localparam int N_TRACKS     = 2;
   localparam int TICK_DIV     = 10;
   localparam int DEBOUNCE_CYC = 4;
   localparam int WARN_TICKS   = 3;
   localparam int CLEAR_TICKS  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  sensor;
   logic        force_close;
   logic        led_gate_down;
   logic        led_gate_up;
   logic        led_warn;
   logic [1:0]  state;
   logic [1:0]  occ_cnt;
   logic [15:0] pass_cnt;

   int checks = 0;
   int errors = 0;

   rail_gate_ctrl #(
      .N_TRACKS     (N_TRACKS),
      .TICK_DIV     (TICK_DIV),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .WARN_TICKS   (WARN_TICKS),
      .CLEAR_TICKS  (CLEAR_TICKS)
   ) dut (
      .clk_100MHz    (clk),
      .reset         (reset),
      .sensor        (sensor),
      .force_close   (force_close),
      .led_gate_down (led_gate_down),
      .led_gate_up   (led_gate_up),
      .led_warn      (led_warn),
      .state         (state),
      .occ_cnt       (occ_cnt),
      .pass_cnt      (pass_cnt)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Phases: 0 OPEN, 1 WARN, 2 CLOSED, 3 CLEAR.
   bit          m_s1[2], m_s2[2], m_deb[2];
   int          m_run[2];
   bit          m_f1, m_f2;
   int          m_edges;       // edges since reset; tick when edges mod TICK_DIV hits TICK_DIV-1
   int          m_phase;
   int          m_ticks_left;  // ticks still needed to finish WARN/CLEAR
   bit          m_warn;
   int          m_occ;
   logic [15:0] m_pass;

   task automatic model_edge();
      bit tick;
      bit occ;
      int nph;
      if (reset) begin
         for (int t = 0; t < 2; t++) begin
            m_s1[t] = 0; m_s2[t] = 0; m_deb[t] = 0; m_run[t] = 0;
         end
         m_f1 = 0; m_f2 = 0; m_edges = 0; m_phase = 0; m_ticks_left = 0;
         m_warn = 0; m_occ = 0; m_pass = 16'd0;
         return;
      end
      tick = ((m_edges % TICK_DIV) == TICK_DIV - 1);
      occ  = m_deb[0] || m_deb[1] || m_f2;
      nph  = m_phase;
      case (m_phase)
         0: if (occ) nph = 1;
         1: if (tick && m_ticks_left == 1) nph = 2;
         2: if (!occ) nph = 3;
         default: begin
            if (occ) nph = 2;
            else if (tick && m_ticks_left == 1) begin
               nph = 0;
               m_pass = m_pass + 16'd1;
            end
         end
      endcase
      if (nph != m_phase) begin
         m_ticks_left = (nph == 1) ? WARN_TICKS : (nph == 3) ? CLEAR_TICKS : 0;
         m_warn = 0;
      end else begin
         if (tick && m_ticks_left > 0) m_ticks_left--;
         if (tick && (nph == 1 || nph == 3)) m_warn = !m_warn;
      end
      m_phase = nph;
      m_occ   = int'(m_deb[0]) + int'(m_deb[1]);
      for (int t = 0; t < 2; t++) begin
         if (m_s2[t] != m_deb[t]) begin
            m_run[t]++;
            if (m_run[t] == DEBOUNCE_CYC) begin
               m_deb[t] = m_s2[t];
               m_run[t] = 0;
            end
         end else begin
            m_run[t] = 0;
         end
         m_s2[t] = m_s1[t];
         m_s1[t] = sensor[t];
      end
      m_f2 = m_f1;
      m_f1 = force_close;
      m_edges++;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert ((obs >= lo) && (obs <= hi)) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Phase duration bookkeeping from the observed state output.
   int cyc = 0;
   int t_enter = 0;
   int prev_st = 0;
   int dur[4];

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("state",     32'(state),         32'(m_phase));
      chk("gate_up",   32'(led_gate_up),   32'(m_phase == 0));
      chk("gate_down", 32'(led_gate_down), 32'(m_phase >= 2));
      chk("warn_led",  32'(led_warn),      32'(m_warn));
      chk("occ_cnt",   32'(occ_cnt),       32'(m_occ));
      chk("pass_cnt",  32'(pass_cnt),      32'(m_pass));
      if (!$isunknown(state) && (int'(state) != prev_st)) begin
         dur[prev_st] = cyc - t_enter;
         t_enter = cyc;
         prev_st = int'(state);
      end
      cyc++;
   endtask

   task automatic wait_state(input int target, input int max_cyc, output int n);
      n = 0;
      while ((state !== 2'(target)) && (n < max_cyc)) begin
         step();
         n++;
      end
      chk("wait_state", 32'(state), 32'(target));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int first;
      logic [15:0] pass_before;

      reset = 1'b1;
      sensor = 2'b11;
      force_close = 1'b0;

      // Reset held with both sensors high.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_state", 32'(state), 32'd0);
         chk("rst_up",    32'(led_gate_up), 32'd1);
         chk("rst_down",  32'(led_gate_down), 32'd0);
         chk("rst_pass",  32'(pass_cnt), 32'd0);
      end
      reset = 1'b0;
      sensor = 2'b00;
      run(10);

      // Glitch of 3 cycles never reaches occupancy.
      sensor = 2'b01;
      run(3);
      sensor = 2'b00;
      for (int i = 0; i < 15; i++) begin
         step();
         chk("glitch_state", 32'(state), 32'd0);
         chk("glitch_occ",   32'(occ_cnt), 32'd0);
      end

      // 6-cycle pulse: WARN 7 cycles after the rising edge, then the gate
      // still closes and eventually reopens.
      first = -1;
      for (int i = 1; i <= 12; i++) begin
         sensor = (i <= 6) ? 2'b01 : 2'b00;
         step();
         if (first < 0 && state === 2'd1) first = i;
      end
      chk("warn_latency", 32'(first), 32'd7);
      wait_state(2, 60, n);
      chk_range("warn_dur", dur[1], 21, 30);
      wait_state(0, 100, n);
      chk_range("clear_dur", dur[3], 11, 20);
      chk("pass_after_pulse", 32'(pass_cnt), 32'd1);

      // Full sequence with the train held while CLOSED.
      sensor = 2'b01;
      wait_state(2, 80, n);
      chk_range("warn_dur2", dur[1], 21, 30);
      for (int i = 0; i < 25; i++) begin
         step();
         chk("closed_hold", 32'(state), 32'd2);
      end
      sensor = 2'b00;
      wait_state(3, 30, n);
      wait_state(0, 40, n);
      chk_range("clear_dur2", dur[3], 11, 20);
      chk("pass_after_full", 32'(pass_cnt), 32'd2);

      // Re-entry during CLEAR on the other track.
      sensor = 2'b01;
      wait_state(2, 80, n);
      sensor = 2'b00;
      wait_state(3, 30, n);
      pass_before = pass_cnt;
      sensor = 2'b10;
      wait_state(2, 30, n);
      chk("reentry_pass", 32'(pass_cnt), 32'(pass_before));
      sensor = 2'b00;
      wait_state(3, 30, n);
      wait_state(0, 40, n);
      chk_range("reentry_clear_dur", dur[3], 11, 20);
      chk("reentry_pass_inc", 32'(pass_cnt), 32'(pass_before + 16'd1));

      // Both tracks, then drop one.
      sensor = 2'b11;
      wait_state(2, 80, n);
      run(3);
      chk("occ_two", 32'(occ_cnt), 32'd2);
      sensor = 2'b01;
      run(12);
      chk("occ_one", 32'(occ_cnt), 32'd1);
      chk("one_left_closed", 32'(state), 32'd2);
      sensor = 2'b00;
      wait_state(0, 80, n);

      // Override alone drives the full close with no tracks occupied.
      force_close = 1'b1;
      wait_state(1, 10, n);
      chk("fc_latency", 32'(n), 32'd3);
      wait_state(2, 40, n);
      chk("fc_occ", 32'(occ_cnt), 32'd0);
      force_close = 1'b0;
      wait_state(0, 60, n);

      // Randomised traffic, glitches and overrides against the model.
      for (int b = 0; b < 60; b++) begin
         sensor = 2'($urandom_range(0, 3));
         force_close = ($urandom_range(0, 7) == 0);
         run($urandom_range(1, 40));
      end
      sensor = 2'b00;
      force_close = 1'b0;
      wait_state(0, 300, n);

      // Reset mid-sequence with sensors held high, then restart.
      sensor = 2'b11;
      wait_state(2, 80, n);
      reset = 1'b1;
      step();
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_up",    32'(led_gate_up), 32'd1);
      chk("mid_rst_warn",  32'(led_warn), 32'd0);
      chk("mid_rst_occ",   32'(occ_cnt), 32'd0);
      chk("mid_rst_pass",  32'(pass_cnt), 32'd0);
      reset = 1'b0;
      wait_state(1, 20, n);
      chk("restart_latency", 32'(n), 32'd7);
      sensor = 2'b00;
      wait_state(0, 120, n);

      // Wrap of the pass counter.
      m_pass = 16'hFFFF;
      force dut.pass_cnt_d = 16'hFFFF;
      step();
      release dut.pass_cnt_d;
      step();
      chk("preload_pass", 32'(pass_cnt), 32'hFFFF);
      sensor = 2'b01;
      wait_state(2, 80, n);
      sensor = 2'b00;
      wait_state(0, 80, n);
      chk("wrap_pass", 32'(pass_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
